// File: rtl/csa_resolver_pkg.sv
// Shared types and default sizing for the csa_resolver block.
package csa_pkg;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      RESOLVE = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   localparam int W_DEF     = 4;
   localparam int ACC_W_DEF = 8;
   localparam int CHUNK_DEF = 2;
   localparam int NCHUNK    = ACC_W_DEF / CHUNK_DEF;

endpackage

// File: rtl/csa_resolver_if.sv
// Operand input and result output handshakes of csa_resolver.
// Optional out_cnt is present when CSA_RESOLVER_CNT_EN is defined.
interface csa_resolver_if #(
   parameter int W     = 4,
   parameter int ACC_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic             out_ovf;
`ifdef CSA_RESOLVER_CNT_EN
   logic [ACC_W-1:0] out_cnt;

   modport master (output in_valid, in_data, in_last, out_ready,
                   input  in_ready, out_valid, out_sum, out_ovf, out_cnt);
   modport slave  (input  in_valid, in_data, in_last, out_ready,
                   output in_ready, out_valid, out_sum, out_ovf, out_cnt);
`else
   modport master (output in_valid, in_data, in_last, out_ready,
                   input  in_ready, out_valid, out_sum, out_ovf);
   modport slave  (input  in_valid, in_data, in_last, out_ready,
                   output in_ready, out_valid, out_sum, out_ovf);
`endif
endinterface

// File: rtl/csa_resolver_row.sv
// Combinational 3:2 compressor row; carry is pre-shifted, the bit shifted out is reported.
module csa_row #(
   parameter int ACC_W = 8
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   input  logic [ACC_W-1:0] x,
   output logic [ACC_W-1:0] sum,
   output logic [ACC_W-1:0] carry,
   output logic             drop
);
   logic [ACC_W-1:0] maj;

   always_comb begin
      maj   = (a & b) | (a & x) | (b & x);
      sum   = a ^ b ^ x;
      carry = {maj[ACC_W-2:0], 1'b0};
      drop  = maj[ACC_W-1];
   end
endmodule

// File: rtl/csa_resolver.sv
// Streaming carry-save accumulator with chunked final resolve.
// Define CSA_RESOLVER_CNT_EN to add the per-packet beat counter on out_cnt.
//
// state   | meaning
// ACCUM   | accepting operands, folding into s/c pair
// RESOLVE | carry-propagating one CHUNK per cycle into out_sum
// OUTPUT  | result presented, waiting for out_ready
module csa_resolver
   import csa_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   csa_resolver_if.slave bus
);
   localparam int NCH   = ACC_W / CHUNK;
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] s_q, s_d, c_q, c_d;
   logic             ovf_q, ovf_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             cy_q, cy_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic             res_ovf_q, res_ovf_d;

   logic [ACC_W-1:0] row_sum, row_carry;
   logic             row_drop;
   logic [CHUNK:0]   part;

   csa_row #(.ACC_W(ACC_W)) u_row (
      .a     (s_q),
      .b     (c_q),
      .x     (ACC_W'(bus.in_data)),
      .sum   (row_sum),
      .carry (row_carry),
      .drop  (row_drop)
   );

`ifdef CSA_RESOLVER_CNT_EN
   logic [ACC_W-1:0] cnt_q, cnt_d;
`endif

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      c_d       = c_q;
      ovf_d     = ovf_q;
      idx_d     = idx_q;
      cy_d      = cy_q;
      sum_d     = sum_q;
      res_ovf_d = res_ovf_q;
      part      = '0;
`ifdef CSA_RESOLVER_CNT_EN
      cnt_d     = cnt_q;
`endif
      unique case (state_q)
         ACCUM: begin
            if (bus.in_valid) begin
               s_d   = row_sum;
               c_d   = row_carry;
               ovf_d = ovf_q | row_drop;
`ifdef CSA_RESOLVER_CNT_EN
               if (cnt_q != {ACC_W{1'b1}}) cnt_d = cnt_q + 1'b1;
`endif
               if (bus.in_last) begin
                  state_d = RESOLVE;
                  idx_d   = '0;
                  cy_d    = 1'b0;
               end
            end
         end
         RESOLVE: begin
            for (int i = 0; i < NCH; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  part = {1'b0, s_q[i*CHUNK +: CHUNK]} + {1'b0, c_q[i*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, cy_q};
                  sum_d[i*CHUNK +: CHUNK] = part[CHUNK-1:0];
               end
            end
            cy_d  = part[CHUNK];
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               res_ovf_d = ovf_q | part[CHUNK];
               state_d   = OUTPUT;
            end
         end
         OUTPUT: begin
            if (bus.out_ready) begin
               s_d     = '0;
               c_d     = '0;
               ovf_d   = 1'b0;
               state_d = ACCUM;
`ifdef CSA_RESOLVER_CNT_EN
               cnt_d   = '0;
`endif
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACCUM;
         s_q       <= '0;
         c_q       <= '0;
         ovf_q     <= 1'b0;
         idx_q     <= '0;
         cy_q      <= 1'b0;
         sum_q     <= '0;
         res_ovf_q <= 1'b0;
`ifdef CSA_RESOLVER_CNT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         c_q       <= c_d;
         ovf_q     <= ovf_d;
         idx_q     <= idx_d;
         cy_q      <= cy_d;
         sum_q     <= sum_d;
         res_ovf_q <= res_ovf_d;
`ifdef CSA_RESOLVER_CNT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == OUTPUT);
   assign bus.out_sum   = sum_q;
   assign bus.out_ovf   = res_ovf_q;
`ifdef CSA_RESOLVER_CNT_EN
   assign bus.out_cnt   = cnt_q;
`endif
endmodule

// File: tb/tb_csa_resolver.sv
// Directed bench for csa_resolver with a packet-level reference model.
module tb_csa_resolver;
   import csa_pkg::*;

   localparam int TW = 4;
   localparam int TA = 8;
   localparam int TC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   csa_resolver_if #(.W(TW), .ACC_W(TA)) bus ();
   csa_resolver #(.W(TW), .ACC_W(TA), .CHUNK(TC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vec = 0;
   int fails = 0;
   int cyc = 0;
   int last_cyc = 0;
   int rise_cyc = 0;
   int hi_len = 0;
   logic pv = 1'b0;

   int got_s[$], got_o[$], got_c[$];
   int mq_s[$], mq_o[$], mq_c[$];

   task automatic chk(input string nm, input int act, input int exp);
      vec++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: packet total as a plain integer, resolve modelled only as a fixed delay.
   int m_mode = 0;   // 0 accepting, 1 resolving, 2 result shown
   int m_tot = 0;
   int m_beats = 0;
   int m_rem = 0;
   int m_sum = 0, m_ovf = 0, m_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_tot = 0; m_beats = 0; m_rem = 0;
         m_sum = 0; m_ovf = 0; m_cnt = 0;
      end else begin
         cyc++;
         case (m_mode)
            0: if (bus.in_valid) begin
               m_tot += int'(bus.in_data);
               if (m_beats < 255) m_beats++;
               if (bus.in_last) begin m_mode = 1; m_rem = NCHUNK; end
            end
            1: begin
               m_rem--;
               if (m_rem == 0) begin
                  m_mode = 2;
                  m_sum = m_tot % 256;
                  m_ovf = (m_tot >= 256) ? 1 : 0;
                  m_cnt = m_beats;
               end
            end
            default: if (bus.out_ready) begin
               mq_s.push_back(m_sum); mq_o.push_back(m_ovf); mq_c.push_back(m_cnt);
               m_mode = 0; m_tot = 0; m_beats = 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", int'(bus.in_ready), (m_mode == 0) ? 1 : 0);
         chk("out_valid", int'(bus.out_valid), (m_mode == 2) ? 1 : 0);
         if (m_mode == 2) begin
            chk("out_sum", int'(bus.out_sum), m_sum);
            chk("out_ovf", int'(bus.out_ovf), m_ovf);
`ifdef CSA_RESOLVER_CNT_EN
            chk("out_cnt", int'(bus.out_cnt), m_cnt);
`endif
         end
         if (bus.out_valid && !pv) begin rise_cyc = cyc; hi_len = 0; end
         if (bus.out_valid) hi_len++;
         if (bus.out_valid && bus.out_ready) begin
            got_s.push_back(int'(bus.out_sum));
            got_o.push_back(int'(bus.out_ovf));
`ifdef CSA_RESOLVER_CNT_EN
            got_c.push_back(int'(bus.out_cnt));
`else
            got_c.push_back(0);
`endif
         end
         pv = bus.out_valid;
      end else begin
         pv = 1'b0;
      end
   end

   task automatic send(input logic [TW-1:0] d, input logic l);
      int t = 0;
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         t++;
         if (t > 100) begin chk("send_timeout", 1, 0); break; end
      end
      @(posedge clk); #1;
      if (l) last_cyc = cyc;
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
   endtask

   task automatic wait_results(input int n);
      int t = 0;
      while (got_s.size() < n && t < 200) begin @(posedge clk); t++; end
      #1;
      chk("result_count", got_s.size(), n);
   endtask

   task automatic clear_q();
      got_s.delete(); got_o.delete(); got_c.delete();
      mq_s.delete(); mq_o.delete(); mq_c.delete();
   endtask

   task automatic check_res(input int i, input int s, input int o);
      if (got_s.size() > i) begin
         chk("lit_sum", got_s[i], s);
         chk("lit_ovf", got_o[i], o);
      end else chk("lit_missing", got_s.size(), i + 1);
      if (mq_s.size() > i) chk("model_sum", mq_s[i], s);
      else chk("model_missing", mq_s.size(), i + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      idle(3);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_sum", int'(bus.out_sum), 0);
      chk("rst_out_ovf", int'(bus.out_ovf), 0);
      idle(1);

      // Basic packet with latency and one-cycle output
      bus.out_ready = 1'b1;
      clear_q();
      send(4'd2, 1'b0); send(4'd1, 1'b0); send(4'd4, 1'b1);
      wait_results(1);
      idle(2);
      check_res(0, 7, 0);
      chk("latency", rise_cyc - last_cyc, 4);
      chk("valid_len", hi_len, 1);

      // Back-to-back packets
      clear_q();
      send(4'd3, 1'b0); send(4'd2, 1'b0); send(4'd0, 1'b1);
      send(4'd10, 1'b0); send(4'd1, 1'b0); send(4'd2, 1'b1);
      send(4'd13, 1'b0); send(4'd9, 1'b0); send(4'd3, 1'b1);
      wait_results(3);
      idle(1);
      check_res(0, 5, 0); check_res(1, 13, 0); check_res(2, 25, 0);

      // Overflow boundary
      clear_q();
      for (int i = 0; i < 18; i++) send(4'd15, (i == 17));
      wait_results(1);
      for (int i = 0; i < 17; i++) send(4'd15, (i == 16));
      wait_results(2);
      idle(1);
      check_res(0, 14, 1); check_res(1, 255, 0);

      // Output backpressure with ignored input beats
      clear_q();
      bus.out_ready = 1'b0;
      send(4'd4, 1'b0); send(4'd5, 1'b0); send(4'd8, 1'b1);
      begin
         int t = 0;
         while (!bus.out_valid && t < 50) begin @(negedge clk); t++; end
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_data = 4'd9; bus.in_last = 1'b0;
      idle(6);
      bus.in_valid = 1'b0;
      chk("stall_no_handshake", got_s.size(), 0);
      chk("stall_valid_held", int'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      wait_results(1);
      idle(1);
      check_res(0, 17, 0);

      // Reset during resolve discards packet
      clear_q();
      send(4'd13, 1'b0); send(4'd9, 1'b0); send(4'd3, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(8);
      chk("rst_discard", got_s.size(), 0);
      send(4'd1, 1'b1);
      wait_results(1);
      idle(1);
      check_res(0, 1, 0);

`ifdef CSA_RESOLVER_CNT_EN
      clear_q();
      for (int i = 0; i < 5; i++) send(4'd1, (i == 4));
      wait_results(1);
      send(4'd6, 1'b0); send(4'd7, 1'b1);
      wait_results(2);
      idle(1);
      check_res(0, 5, 0); check_res(1, 13, 0);
      if (got_c.size() > 1) begin
         chk("lit_cnt0", got_c[0], 5);
         chk("lit_cnt1", got_c[1], 2);
      end else chk("cnt_missing", got_c.size(), 2);
      if (mq_c.size() > 1) begin
         chk("model_cnt0", mq_c[0], 5);
         chk("model_cnt1", mq_c[1], 2);
      end else chk("model_cnt_missing", mq_c.size(), 2);
`endif

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
      $finish;
   end
endmodule

// File: doc/csa_resolver.md
Name: csa_resolver

Overview:
- Streaming multi-operand accumulator. It sits downstream of the carry-save adder stage.
- Operands arrive over a valid/ready handshake and are folded into a redundant sum/carry pair, one 3:2 compression per accepted beat.
- On the beat flagged last, it resolves the redundant pair with a chunked carry-propagate adder. It then presents the binary total and an overflow flag on a valid/ready output.

Parameters:
- W, 4, operand width in bits.
- ACC_W, 8, accumulator and result width; ACC_W >= W.
- CHUNK, 2, bits resolved per cycle in the final adder; ACC_W % CHUNK == 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  W  unsigned operand, zero-extended to ACC_W.
- in_last  input  1  marks final operand of a packet; sampled with in_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  ACC_W  resolved total, mod 2^ACC_W.
- out_ovf  output  1  true total >= 2^ACC_W.

Behaviour:
- Reset: state=ACCUM, s_reg=0, c_reg=0, ovf_reg=0, in_ready=1, out_valid=0, out_sum=0, out_ovf=0. Assertion mid-resolve or mid-output discards the packet immediately.
- States: ACCUM, RESOLVE, OUTPUT.
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready:
    - s_reg <= s^c^x.
    - c_reg <= maj(s,c,x)<<1, truncated to ACC_W.
    - If the dropped MSB of maj is 1, set ovf_reg.
  - If in_last is also set, go to RESOLVE and clear chunk index and carry-in.
  - No beat means no change.
- RESOLVE:
  - in_ready=0.
  - Each cycle, add CHUNK bits of s_reg and c_reg (LSB chunk first) plus the running carry. Write the chunk result into out_sum.
  - Takes ACC_W/CHUNK cycles.
  - On the final chunk: set out_ovf = ovf_reg | final carry out, then go to OUTPUT.
- OUTPUT:
  - out_valid=1, in_ready=0.
  - out_sum and out_ovf are held stable while out_valid && !out_ready.
  - On out_ready:
    - out_valid drops next cycle.
    - s_reg, c_reg and ovf_reg clear.
    - State returns to ACCUM.
- Latency: last-beat edge at cycle N, out_valid high from cycle N+ACC_W/CHUNK. Default is 4 cycles.
- Single-operand packet (in_last on first beat): result = operand, out_ovf=0.
- in_valid while in_ready=0 is ignored; upstream must hold it.
- out_ready asserted while out_valid=0 has no effect.
- Zero-length packets do not exist; every packet has at least one beat.

Optional Feature:
- CSA_RESOLVER_CNT_EN.
- Defined:
  - Adds output port out_cnt, width ACC_W, holding the number of beats accepted in the packet.
  - Stable with out_sum; cleared on the output handshake and on reset.
  - Saturates at 2^ACC_W-1.
- Undefined: no port, no counter logic. All other behaviour identical.

Decomposition:
- Package csa_pkg:
  - state enum (ACCUM, RESOLVE, OUTPUT).
  - default constants for W, ACC_W, CHUNK.
  - localparam NCHUNK = ACC_W/CHUNK.
- Sub-module csa_row, parameterised ACC_W:
  - purely combinational 3:2 compressor row.
  - outputs sum vector, shifted carry vector and dropped-MSB bit.
  - instantiated once in ACCUM.
- The chunk adder stays inline.

Test Plan:
- Packet 2,1,4 (last on 4), out_ready=1 -> out_sum=7, out_ovf=0; out_valid rises exactly 4 cycles after the last-beat edge and lasts 1 cycle.
- Packets 3,2,0 then 10,1,2 then 13,9,3 back-to-back -> 5, 13, 25 in order, ovf=0; in_ready low from each last beat until each output handshake.
- 18 beats of 15 -> out_sum=14 (270 mod 256), out_ovf=1. 17 beats of 15 -> out_sum=255, out_ovf=0.
- Output backpressure: 4,5,8 with out_ready low for 6 cycles -> out_sum=17 held stable; in_valid beats during the stall are not accepted; result taken on out_ready rise.
- rst_n pulsed low in cycle 2 of RESOLVE for packet 13,9,3 -> out_valid never rises; next packet 1 (single beat) -> out_sum=1, out_ovf=0.
- With CSA_RESOLVER_CNT_EN: 5-beat packet of 1s -> out_sum=5, out_cnt=5; next 2-beat packet -> out_cnt=2.
